hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage core: it watches the instruction in ID against a shadow record of the two older in-flight instructions (EX, MEM). From that it generates the PC/IF-ID/ID-EX enables, the flush/bubble controls, and registered forwarding selects for the ALU operands. It sits beside the ID stage and consumes the decoder's register fields plus the EX-stage branch resolution and data-memory wait. It also keeps saturating bubble and flush counters for performance debug.

## Interface
Parameters
- CNT_W, 16: width of each performance counter.

Ports
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  decoder source register addresses (`regAddr`).
- id_rs1_used, id_rs2_used  in  1  the source operand is actually read.
- id_rd  in  5  decoder destination register.
- id_reg_write  in  1  decoder registerWriteEnable.
- id_is_load  in  1  decoder regSelect; 1 means the register writeback comes from data memory.
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle.
- mem_stall_req  in  1  data memory not ready; freeze pipeline.
- pc_en, if_id_en, id_ex_en  out  1  pipeline register load enables.
- if_id_flush, id_ex_flush  out  1  load a bubble (NOP, valid=0) into the register.
- fwd_a_sel, fwd_b_sel  out  2  registered forward selects for the instruction now in EX: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- bubble_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Shadow state: two entries, EX and MEM, each holding {valid, rd, reg_write, is_load}. The shadow is cleared by rst.
- A load-use hazard (lu) is raised when all of the following hold:
  - id_valid;
  - EX.valid, EX.is_load and EX.rd != 0;
  - (id_rs1_used && id_rs1 == EX.rd) || (id_rs2_used && id_rs2 == EX.rd).
- Forward pick for each source register of the ID instruction:
  - 01 if EX.valid && EX.reg_write && EX.rd != 0 && the register matches;
  - else 10 if MEM matches under the same condition;
  - else 00.
- EX has priority over MEM. x0 never forwards.
- Cycle modes are evaluated with priority rst > MEM_WAIT > FLUSH > LU_STALL > RUN.
  - MEM_WAIT (mem_stall_req=1): all enables 0, both flushes 0. Shadow, fwd registers and counters hold. ex_branch_taken is ignored because the branch stays frozen in EX and is re-presented next cycle.
  - FLUSH (ex_branch_taken=1): pc_en=1 (PC takes the target), if_id_en=1, id_ex_en=1, if_id_flush=1, id_ex_flush=1. MEM <= EX, EX <= invalid, fwd registers <= 00, flush_cnt++. The pending lu is discarded.
  - LU_STALL (lu=1): pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, if_id_flush=0. MEM <= EX, EX <= invalid, fwd registers <= 00, bubble_cnt++. The next cycle re-evaluates with the load now in MEM and forwards 10.
  - RUN: all enables 1, flushes 0. MEM <= EX, EX <= {id_valid, id_rd, id_reg_write, id_is_load}, fwd registers <= the forward picks.
- Counters saturate at all-ones and do not wrap.
- The register file is write-through (a WB write is visible to an ID read in the same cycle), so no WB shadow entry exists.

## Timing
- Reset (async, takes effect immediately):
  - shadow invalid, fwd_a_sel = fwd_b_sel = 00, counters 0;
  - while rst is high, all enables are 0 and both flushes are 0.
- After rst deasserts, the first cycle is RUN: enables = 1.
- Enables and flushes are combinational from the current inputs and shadow, valid in the same cycle.
- fwd_*_sel are registered with 1-cycle latency and align with the instruction entering EX.
- A load-use stall costs exactly one bubble. A taken branch costs two squashed instructions in a single flush cycle.
- Reset asserted mid-stall or mid-flush aborts the event: the shadow clears and no counter increments for that cycle.
- With mem_stall_req and ex_branch_taken both high, no flush occurs. The flush happens in the first cycle mem_stall_req is low, provided ex_branch_taken is still high.

## Structure
- Types.v gains:
  - `hazardEntry` (valid, 5-bit rd, reg_write, is_load);
  - `fwdSel` (2-bit);
  - constants FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
- One sub-module, `reg_match`: given an entry, a source address and its used flag, it outputs hit and load_hit. It is instantiated four times (rs1/rs2 × EX/MEM).
- The counters are inline. No separate FSM register is needed because the mode is decoded each cycle.

## Test plan
- Back-to-back ALU dependency: `add x5,…` then `sub x6,x5,x1` → no stall; the cycle after `sub` enters EX, fwd_a_sel = 01. With one unrelated instruction between them → fwd_a_sel = 10.
- Load-use: `lw x7,…` then `add x8,x7,x7` → one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1, bubble_cnt 0→1. Next, `add` enters EX with fwd_a_sel = fwd_b_sel = 10.
- x0 and unused sources:
  - `lw x0` followed by a reader of x0 → no stall, fwd = 00;
  - `lw x7` followed by an instruction with id_rs2 = 7 and id_rs2_used = 0 → no stall.
- Branch over load-use: ex_branch_taken = 1 while lu is true → if_id_flush = id_ex_flush = 1, pc_en = 1, flush_cnt +1, bubble_cnt unchanged.
- Memory wait: mem_stall_req high for 3 cycles together with ex_branch_taken → enables 0, shadow and fwd held. The flush fires on the 4th cycle.
- Saturation and reset: with CNT_W = 2, force 5 load-use stalls → bubble_cnt = 3. Assert rst mid-stall → all outputs at their reset values asynchronously.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef logic [4:0] reg_addr_t;

    // Shadow record of one in-flight instruction (EX or MEM).
    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      reg_write;
        logic      is_load;
    } hazard_entry_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG   = 2'b00;
    localparam fwd_sel_t FWD_EXMEM = 2'b01;
    localparam fwd_sel_t FWD_MEMWB = 2'b10;

    // Cycle mode, decoded fresh every cycle (no state register).
    typedef enum logic [1:0] {
        ModeRun,
        ModeLuStall,
        ModeFlush,
        ModeMemWait
    } mode_e;

    // The youngest producer wins: EX beats MEM.
    function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end else if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder/pipeline-facing bundle of the hazard controller.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic      id_valid;
    reg_addr_t id_rs1;
    reg_addr_t id_rs2;
    logic      id_rs1_used;
    logic      id_rs2_used;
    reg_addr_t id_rd;
    logic      id_reg_write;
    logic      id_is_load;
    logic      ex_branch_taken;
    logic      mem_stall_req;

    logic      pc_en;
    logic      if_id_en;
    logic      id_ex_en;
    logic      if_id_flush;
    logic      id_ex_flush;
    fwd_sel_t  fwd_a_sel;
    fwd_sel_t  fwd_b_sel;

    // Pipeline side: presents decode fields, consumes controls.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_reg_write, id_is_load, ex_branch_taken, mem_stall_req,
        input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, fwd_a_sel, fwd_b_sel
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_reg_write, id_is_load, ex_branch_taken, mem_stall_req,
        output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, fwd_a_sel, fwd_b_sel
    );

endinterface

// File: rtl/hazard_ctrl_reg_match.sv
// Compares one source operand against one shadow entry.
module hazard_ctrl_reg_match
    import hazard_ctrl_pkg::*;
(
    input  hazard_entry_t entry,
    input  reg_addr_t     addr,
    input  logic          used,
    output logic          hit,
    output logic          load_hit
);

    logic match;

    // x0 never matches: it is hardwired and never forwards or stalls.
    assign match    = used && entry.valid && (entry.rd != '0) && (addr == entry.rd);
    assign hit      = match && entry.reg_write;
    assign load_hit = match && entry.is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and operand-forward control beside the ID stage.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     bus,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_entry_t    ex_q, ex_d, mem_q, mem_d;
    fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] bubble_q, bubble_d, flush_q, flush_d;
    mode_e            mode;

    logic rs1_ex_hit, rs1_ex_load, rs1_mem_hit, rs1_mem_load;
    logic rs2_ex_hit, rs2_ex_load, rs2_mem_hit, rs2_mem_load;
    logic lu;

    hazard_ctrl_reg_match u_rs1_ex (
        .entry(ex_q), .addr(bus.id_rs1), .used(bus.id_rs1_used),
        .hit(rs1_ex_hit), .load_hit(rs1_ex_load)
    );
    hazard_ctrl_reg_match u_rs2_ex (
        .entry(ex_q), .addr(bus.id_rs2), .used(bus.id_rs2_used),
        .hit(rs2_ex_hit), .load_hit(rs2_ex_load)
    );
    hazard_ctrl_reg_match u_rs1_mem (
        .entry(mem_q), .addr(bus.id_rs1), .used(bus.id_rs1_used),
        .hit(rs1_mem_hit), .load_hit(rs1_mem_load)
    );
    hazard_ctrl_reg_match u_rs2_mem (
        .entry(mem_q), .addr(bus.id_rs2), .used(bus.id_rs2_used),
        .hit(rs2_mem_hit), .load_hit(rs2_mem_load)
    );

    // A load in MEM is already forwardable, so only the EX load can stall.
    logic unused_mem_load;
    assign unused_mem_load = rs1_mem_load ^ rs2_mem_load;

    assign lu = bus.id_valid && (rs1_ex_load || rs2_ex_load);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1'b1);
    endfunction

    // Mode decode: a frozen pipeline outranks the branch, the branch outranks the stall.
    always_comb begin
        if (bus.mem_stall_req) begin
            mode = ModeMemWait;
        end else if (bus.ex_branch_taken) begin
            mode = ModeFlush;
        end else if (lu) begin
            mode = ModeLuStall;
        end else begin
            mode = ModeRun;
        end
    end

    // State register: shadow, forward selects and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= '0;
            mem_q    <= '0;
            fwd_a_q  <= FWD_REG;
            fwd_b_q  <= FWD_REG;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    // Next-state: the shadow advances unless memory freezes the pipeline.
    always_comb begin
        ex_d     = ex_q;
        mem_d    = mem_q;
        fwd_a_d  = fwd_a_q;
        fwd_b_d  = fwd_b_q;
        bubble_d = bubble_q;
        flush_d  = flush_q;
        unique case (mode)
            ModeMemWait: ;
            ModeFlush: begin
                mem_d   = ex_q;
                ex_d    = '0;
                fwd_a_d = FWD_REG;
                fwd_b_d = FWD_REG;
                flush_d = sat_inc(flush_q);
            end
            ModeLuStall: begin
                mem_d    = ex_q;
                ex_d     = '0;
                fwd_a_d  = FWD_REG;
                fwd_b_d  = FWD_REG;
                bubble_d = sat_inc(bubble_q);
            end
            ModeRun: begin
                mem_d   = ex_q;
                ex_d    = '{valid:     bus.id_valid,
                            rd:        bus.id_rd,
                            reg_write: bus.id_reg_write,
                            is_load:   bus.id_is_load};
                fwd_a_d = fwd_pick(rs1_ex_hit, rs1_mem_hit);
                fwd_b_d = fwd_pick(rs2_ex_hit, rs2_mem_hit);
            end
            default: ;
        endcase
    end

    // Outputs: enables/flushes are combinational and forced quiet during reset.
    always_comb begin
        bus.pc_en       = 1'b0;
        bus.if_id_en    = 1'b0;
        bus.id_ex_en    = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        if (!rst) begin
            unique case (mode)
                ModeMemWait: ;
                ModeFlush: begin
                    bus.pc_en       = 1'b1;
                    bus.if_id_en    = 1'b1;
                    bus.id_ex_en    = 1'b1;
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                end
                ModeLuStall: begin
                    bus.id_ex_en    = 1'b1;
                    bus.id_ex_flush = 1'b1;
                end
                ModeRun: begin
                    bus.pc_en    = 1'b1;
                    bus.if_id_en = 1'b1;
                    bus.id_ex_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.fwd_a_sel = fwd_a_q;
    assign bus.fwd_b_sel = fwd_b_q;
    assign bubble_cnt    = bubble_q;
    assign flush_cnt     = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios, then random traffic.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] bubble_cnt, flush_cnt;

    hazard_ctrl_if bus();

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the two older in-flight instructions, youngest first.
    typedef struct { bit v; int rd; bit wr; bit ld; } instr_t;
    instr_t inflight[2];
    int m_fa, m_fb, m_bub, m_fl;

    typedef struct {
        bit rst; bit mid_rst; bit iv;
        int rs1; bit u1; int rs2; bit u2;
        int rd; bit wr; bit ld; bit br; bit ms;
    } stim_t;

    // en = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}
    typedef struct { logic [4:0] en; int fa; int fb; int bub; int fl; } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) inflight[i] = '{0, 0, 0, 0};
        m_fa = 0; m_fb = 0; m_bub = 0; m_fl = 0;
    endfunction

    // 1 = value comes from the instruction one ahead, 2 = two ahead, 0 = register file.
    function automatic int producer(int rs, bit used);
        for (int age = 0; age < 2; age++)
            if (used && rs != 0 && inflight[age].v && inflight[age].wr && inflight[age].rd == rs)
                return age + 1;
        return 0;
    endfunction

    function automatic stim_t mk(bit iv, int rs1, bit u1, int rs2, bit u2,
                                 int rd, bit wr, bit ld, bit br, bit ms);
        stim_t s;
        s = '{0, 0, iv, rs1, u1, rs2, u2, rd, wr, ld, br, ms};
        return s;
    endfunction

    // Called just after a rising edge; drives one cycle and queues its expectation.
    task automatic step(input stim_t s);
        exp_t e;
        bit   any_rst, lu;
        int   na, nb;
        rst                 = s.rst;
        bus.id_valid        = s.iv;
        bus.id_rs1          = 5'(s.rs1);
        bus.id_rs1_used     = s.u1;
        bus.id_rs2          = 5'(s.rs2);
        bus.id_rs2_used     = s.u2;
        bus.id_rd           = 5'(s.rd);
        bus.id_reg_write    = s.wr;
        bus.id_is_load      = s.ld;
        bus.ex_branch_taken = s.br;
        bus.mem_stall_req   = s.ms;
        if (s.mid_rst) #1 rst = 1'b1;
        any_rst = s.rst || s.mid_rst;
        lu = s.iv && inflight[0].v && inflight[0].ld && inflight[0].rd != 0 &&
             ((s.u1 && s.rs1 == inflight[0].rd) || (s.u2 && s.rs2 == inflight[0].rd));
        if (any_rst) begin
            model_clear();
            e.en = 5'b00000;
        end else if (s.ms) e.en = 5'b00000;
        else if (s.br)     e.en = 5'b11111;
        else if (lu)       e.en = 5'b00101;
        else               e.en = 5'b11100;
        e.fa = m_fa; e.fb = m_fb; e.bub = m_bub; e.fl = m_fl;
        exp_q.push_back(e);
        na = producer(s.rs1, s.u1);
        nb = producer(s.rs2, s.u2);
        @(posedge clk);
        if (any_rst) begin
            model_clear();
        end else if (!s.ms) begin
            inflight[1] = inflight[0];
            if (s.br || lu) begin
                inflight[0] = '{0, 0, 0, 0};
                m_fa = 0; m_fb = 0;
                if (s.br) m_fl  = (m_fl  < CMAX) ? m_fl + 1  : CMAX;
                else      m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
            end else begin
                inflight[0] = '{s.iv, s.rd, s.wr, s.ld};
                m_fa = na; m_fb = nb;
            end
        end
        #1;
    endtask

    // Monitor: outputs are steady mid-cycle, compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.if_id_flush, bus.id_ex_flush}
                    !== e.en) begin
                    errors++;
                    $display("FAIL enables t=%0t got %b want %b", $time,
                             {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.if_id_flush,
                              bus.id_ex_flush}, e.en);
                end
                checks++;
                if ({bus.fwd_a_sel, bus.fwd_b_sel} !== {2'(e.fa), 2'(e.fb)}) begin
                    errors++;
                    $display("FAIL fwd t=%0t got a=%b b=%b want a=%0d b=%0d", $time,
                             bus.fwd_a_sel, bus.fwd_b_sel, e.fa, e.fb);
                end
                checks++;
                if ({bubble_cnt, flush_cnt} !== {CW'(e.bub), CW'(e.fl)}) begin
                    errors++;
                    $display("FAIL counters t=%0t got bub=%0d fl=%0d want bub=%0d fl=%0d",
                             $time, bubble_cnt, flush_cnt, e.bub, e.fl);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        model_clear();
        rst = 1'b0;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 0;
        bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_reg_write = 0; bus.id_is_load = 0;
        bus.ex_branch_taken = 0; bus.mem_stall_req = 0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); s.rst = 1;
        step(s);
        // add x5 ; sub x6,x5,x1 ; filler -> fwd_a 01
        step(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0));
        step(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0));
        step(mk(1, 3, 1, 4, 1, 9, 1, 0, 0, 0));
        // add x5 ; unrelated ; sub x6,x5,x1 -> fwd_a 10
        step(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0));
        step(mk(1, 3, 1, 4, 1, 9, 1, 0, 0, 0));
        step(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // lw x7 ; add x8,x7,x7 (stall, then re-presented) -> fwd 10/10
        step(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0));
        step(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0));
        step(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // lw x0 ; reader of x0 -> no stall, no forward
        step(mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        step(mk(1, 0, 1, 0, 1, 8, 1, 0, 0, 0));
        // lw x7 ; rs2=7 but unused -> no stall
        step(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0));
        step(mk(1, 3, 1, 7, 0, 8, 1, 0, 0, 0));
        // branch over load-use
        step(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0));
        step(mk(1, 7, 1, 7, 1, 8, 1, 0, 1, 0));
        // memory wait with pending branch for 3 cycles, flush on the 4th
        step(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) step(mk(1, 5, 1, 5, 1, 6, 1, 0, 1, 1));
        step(mk(1, 5, 1, 5, 1, 6, 1, 0, 1, 0));
        // five load-use stalls saturate the 2-bit bubble counter
        for (int i = 0; i < 5; i++) begin
            step(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0));
            step(mk(1, 7, 1, 2, 1, 8, 1, 0, 0, 0));
            step(mk(1, 7, 1, 2, 1, 8, 1, 0, 0, 0));
        end
        // reset asserted in the middle of a stall cycle
        step(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0));
        s = mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0); s.mid_rst = 1;
        step(s);
        step(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0));
        // random traffic over a small register set to provoke many hazards
        for (int i = 0; i < 2000; i++) begin
            s.rst     = ($urandom_range(99) == 0);
            s.mid_rst = ($urandom_range(199) == 0);
            s.iv      = ($urandom_range(7) != 0);
            s.rs1     = int'($urandom_range(3));
            s.u1      = ($urandom_range(4) != 0);
            s.rs2     = int'($urandom_range(3));
            s.u2      = ($urandom_range(2) != 0);
            s.rd      = int'($urandom_range(3));
            s.wr      = ($urandom_range(4) != 0);
            s.ld      = ($urandom_range(2) == 0);
            s.br      = ($urandom_range(7) == 0);
            s.ms      = ($urandom_range(5) == 0);
            step(s);
        end
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
